pll_reconfig_seq: RTL and testbench

PLL_RECONFIG_SEQ -- requirements
Module: pll_reconfig_seq

---
 rtl/pll_reconfig_seq.sv | 166 ++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: holds a table of 160-bit PLL profiles and, on request, streams
// the selected profile into the reconfig register block over Avalon-MM, starts it and polls status.
module pll_reconfig_seq #(
  parameter int unsigned NUM_PROFILES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned ProfW         = $clog2(NUM_PROFILES),
  localparam int unsigned CntW          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             prof_we_i,
  input  logic [ProfW+2:0] prof_addr_i,
  input  logic [31:0]      prof_wdata_i,
  input  logic             req_valid_i,
  input  logic [ProfW-1:0] req_profile_i,
  output logic             req_ready_o,
  output logic [2:0]       avm_address_o,
  output logic [31:0]      avm_writedata_o,
  output logic             avm_write_o,
  output logic             avm_read_o,
  input  logic [31:0]      avm_readdata_i,
  input  logic             avm_waitrequest_n_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [ProfW-1:0] cur_profile_o,
  output logic             cur_valid_o
);

  localparam logic [CntW-1:0] TmoLast  = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]     StartCmd = 32'h0000_0002;

  typedef enum logic [2:0] {StIdle, StWrData, StStart, StPollHi, StPollLo, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [ProfW-1:0] sel_q, sel_d;
  logic [CntW-1:0]  tmo_q, tmo_d;
  logic             error_q, error_d;
  logic [ProfW-1:0] cur_q, cur_d;
  logic             curv_q, curv_d;
  logic [31:0]      prof_q [NUM_PROFILES][5];

  logic [2:0]       wr_word;
  logic [ProfW-1:0] wr_prof;
  logic             tbl_we;
  logic             stat_bit;
  logic             unused_rdata;

  assign wr_word      = prof_addr_i[2:0];
  assign wr_prof      = prof_addr_i[ProfW+2:3];
  assign busy_o       = (state_q != StIdle);
  assign stat_bit     = avm_readdata_i[31];
  assign unused_rdata = ^avm_readdata_i[30:0];

  // The profile being streamed is write-protected while the sequence runs.
  assign tbl_we = prof_we_i && (wr_word < 3'd5) && !(busy_o && (wr_prof == sel_q));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < NUM_PROFILES; p++) begin
        for (int w = 0; w < 5; w++) begin
          prof_q[p][w] <= '0;
        end
      end
    end else if (tbl_we) begin
      prof_q[wr_prof][wr_word] <= prof_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      sel_q   <= '0;
      tmo_q   <= '0;
      error_q <= 1'b0;
      cur_q   <= '0;
      curv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      tmo_q   <= tmo_d;
      error_q <= error_d;
      cur_q   <= cur_d;
      curv_q  <= curv_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    sel_d           = sel_q;
    tmo_d           = tmo_q;
    error_d         = error_q;
    cur_d           = cur_q;
    curv_d          = curv_q;
    req_ready_o     = 1'b0;
    done_o          = 1'b0;
    avm_write_o     = 1'b0;
    avm_read_o      = 1'b0;
    avm_address_o   = 3'd0;
    avm_writedata_o = 32'h0;

    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          error_d = 1'b0;
          sel_d   = req_profile_i;
          idx_d   = 3'd0;
          state_d = (curv_q && (req_profile_i == cur_q)) ? StDone : StWrData;
        end
      end
      StWrData: begin
        // Address 1 carries word 4, address 5 carries word 0.
        avm_write_o     = 1'b1;
        avm_address_o   = 3'd1 + idx_q;
        avm_writedata_o = prof_q[sel_q][3'd4 - idx_q];
        if (avm_waitrequest_n_i) begin
          if (idx_q == 3'd4) begin
            state_d = StStart;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StStart: begin
        avm_write_o     = 1'b1;
        avm_writedata_o = StartCmd;
        if (avm_waitrequest_n_i) begin
          state_d = StPollHi;
          tmo_d   = '0;
        end
      end
      StPollHi, StPollLo: begin
        avm_read_o = 1'b1;
        tmo_d      = tmo_q + CntW'(1);
        if (tmo_q == TmoLast) begin
          error_d = 1'b1;
          curv_d  = 1'b0;
          state_d = StIdle;
        end else if (avm_waitrequest_n_i) begin
          if ((state_q == StPollHi) && stat_bit) begin
            state_d = StPollLo;
          end else if ((state_q == StPollLo) && !stat_bit) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done_o  = 1'b1;
        cur_d   = sel_q;
        curv_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign error_o       = error_q;
  assign cur_profile_o = cur_q;
  assign cur_valid_o   = curv_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Self-checking bench for pll_reconfig_seq: Avalon slave model with configurable stalls,
// scoreboard of expected register writes, profile table model.
module tb_pll_reconfig_seq;

  localparam int unsigned NP  = 4;
  localparam int unsigned PW  = 2;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prof_we = 1'b0;
  logic [PW+2:0] prof_addr = '0;
  logic [31:0]   prof_wdata = '0;
  logic          req_valid = 1'b0;
  logic [PW-1:0] req_profile = '0;
  logic          req_ready;
  logic [2:0]    avm_address;
  logic [31:0]   avm_writedata;
  logic          avm_write;
  logic          avm_read;
  logic [31:0]   avm_readdata = '0;
  logic          wrn = 1'b0;
  logic          busy;
  logic          done;
  logic          error;
  logic [PW-1:0] cur_profile;
  logic          cur_valid;

  pll_reconfig_seq #(
    .NUM_PROFILES  (NP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .prof_we_i          (prof_we),
    .prof_addr_i        (prof_addr),
    .prof_wdata_i       (prof_wdata),
    .req_valid_i        (req_valid),
    .req_profile_i      (req_profile),
    .req_ready_o        (req_ready),
    .avm_address_o      (avm_address),
    .avm_writedata_o    (avm_writedata),
    .avm_write_o        (avm_write),
    .avm_read_o         (avm_read),
    .avm_readdata_i     (avm_readdata),
    .avm_waitrequest_n_i(wrn),
    .busy_o             (busy),
    .done_o             (done),
    .error_o            (error),
    .cur_profile_o      (cur_profile),
    .cur_valid_o        (cur_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] model [NP][5];
  int          checks = 0;
  int          errors = 0;
  int          stall_cfg = 0;
  int          stall_cnt = 0;
  int          status_mode = 0;
  int          rd_num = 0;
  int          done_cnt = 0;
  int          rd_cycles = 0;
  int          bus_cycles = 0;
  logic [2:0]  hold_a;
  logic [31:0] hold_d;
  logic        hold_w;

  // Slave model: stalls each transfer stall_cfg cycles, checks held commands, scores writes.
  always @(negedge clk) begin
    if (rst) begin
      wrn       = 1'b0;
      stall_cnt = 0;
      rd_num    = 0;
    end else begin
      if (!busy) rd_num = 0;
      if (done) done_cnt++;
      if (avm_read) rd_cycles++;
      if (avm_write || avm_read) bus_cycles++;
      if (avm_write && avm_read) begin
        checks++;
        errors++;
        $display("FAIL rd_wr_exclusive: write=%b read=%b, required not both", avm_write, avm_read);
      end
      if (avm_write || avm_read) begin
        if (stall_cnt == 0) begin
          hold_a = avm_address;
          hold_d = avm_writedata;
          hold_w = avm_write;
        end else begin
          checks++;
          if ({avm_address, avm_writedata, avm_write} !== {hold_a, hold_d, hold_w}) begin
            errors++;
            $display("FAIL cmd_stable: got a=%0d d=%h w=%b, required a=%0d d=%h w=%b",
                     avm_address, avm_writedata, avm_write, hold_a, hold_d, hold_w);
          end
        end
        if (stall_cnt < stall_cfg) begin
          wrn = 1'b0;
          stall_cnt++;
        end else begin
          wrn       = 1'b1;
          stall_cnt = 0;
          if (avm_write) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL write_seq: got a=%0d d=%h, required no write", avm_address,
                       avm_writedata);
            end else begin
              e = exp_q.pop_front();
              if ({avm_address, avm_writedata} !== {e.a, e.d}) begin
                errors++;
                $display("FAIL write_seq: got a=%0d d=%h, required a=%0d d=%h", avm_address,
                         avm_writedata, e.a, e.d);
              end
            end
          end else begin
            avm_readdata = (status_mode == 0 && rd_num == 0) ? 32'h8000_0000 : 32'h0000_0000;
            rd_num++;
          end
        end
      end else begin
        wrn       = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  task automatic load_word(input int p, input int w, input logic [31:0] d, input bit upd);
    @(negedge clk);
    prof_we    = 1'b1;
    prof_addr  = {PW'(p), 3'(w)};
    prof_wdata = d;
    if (upd && w < 5) model[p][w] = d;
    @(negedge clk);
    prof_we = 1'b0;
  endtask

  task automatic push_seq(input int p);
    for (int i = 0; i < 5; i++) exp_q.push_back({3'(i + 1), model[p][4 - i]});
    exp_q.push_back({3'd0, 32'h0000_0002});
  endtask

  task automatic issue(input int p);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_before_issue: got %b, required 1", req_ready);
    end
    req_valid   = 1'b1;
    req_profile = PW'(p);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int bound, output int n);
    n = 0;
    while (done_cnt == d0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL done_wait: got no done within %0d cycles, required done pulse", bound);
    end
  endtask

  task automatic check_end(input int p, input string name);
    checks++;
    if ({exp_q.size() == 0, cur_profile, cur_valid, error, busy} !== {1'b1, PW'(p), 3'b100}) begin
      errors++;
      $display("FAIL %s_end: got empty=%b cur=%0d vld=%b err=%b busy=%b, required 1 %0d 1 0 0",
               name, exp_q.size() == 0, cur_profile, cur_valid, error, busy, p);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, busy, done, error, cur_valid, cur_profile} !== {5'b10000, PW'(0)}) begin
      errors++;
      $display("FAIL reset_status: got rdy=%b busy=%b done=%b err=%b vld=%b cur=%0d, required 1 0 0 0 0 0",
               req_ready, busy, done, error, cur_valid, cur_profile);
    end
    checks++;
    if ({avm_write, avm_read, avm_address, avm_writedata} !== 37'h0) begin
      errors++;
      $display("FAIL reset_avm: got w=%b r=%b a=%0d d=%h, required all zero", avm_write, avm_read,
               avm_address, avm_writedata);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_basic;
    int d0, n;
    for (int w = 0; w < 5; w++) load_word(1, w, 32'h11 + w, 1'b1);
    for (int w = 0; w < 5; w++) load_word(2, w, 32'h2000_0000 + w * 32'h11, 1'b1);
    for (int w = 0; w < 5; w++) load_word(3, w, 32'h3300_0000 + w, 1'b1);
    push_seq(1);
    d0 = done_cnt;
    issue(1);
    checks++;
    if ({busy, avm_write} !== 2'b11) begin
      errors++;
      $display("FAIL basic_busy: got busy=%b write=%b, required 1 1", busy, avm_write);
    end
    wait_done(d0, 100, n);
    @(negedge clk);
    #1;
    check_end(1, "basic");
    checks++;
    if (done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL basic_done_count: got %0d, required %0d", done_cnt - d0, 1);
    end
  endtask

  task automatic test_repeat;
    int d0, b0, n;
    d0 = done_cnt;
    b0 = bus_cycles;
    issue(1);
    wait_done(d0, 2, n);
    @(negedge clk);
    #1;
    checks++;
    if (bus_cycles !== b0) begin
      errors++;
      $display("FAIL repeat_no_bus: got %0d bus cycles, required 0", bus_cycles - b0);
    end
    check_end(1, "repeat");
  endtask

  task automatic test_stall;
    int d0, n;
    stall_cfg = 3;
    push_seq(2);
    d0 = done_cnt;
    issue(2);
    wait_done(d0, 200, n);
    @(negedge clk);
    #1;
    check_end(2, "stall");
    stall_cfg = 0;
  endtask

  task automatic test_timeout;
    int d0, r0, n;
    status_mode = 1;
    push_seq(3);
    d0 = done_cnt;
    r0 = rd_cycles;
    issue(3);
    n = 0;
    while (error !== 1'b1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if ({error, cur_valid, busy, req_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL timeout_state: got err=%b vld=%b busy=%b rdy=%b, required 1 0 0 1", error,
               cur_valid, busy, req_ready);
    end
    checks++;
    if (rd_cycles - r0 !== TMO) begin
      errors++;
      $display("FAIL timeout_poll_cycles: got %0d, required %0d", rd_cycles - r0, TMO);
    end
    checks++;
    if (done_cnt !== d0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_no_done: got done=%0d left=%0d, required 0 0", done_cnt - d0,
               exp_q.size());
    end
    status_mode = 0;
    push_seq(1);
    d0 = done_cnt;
    issue(1);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL error_clear: got %b, required 0", error);
    end
    wait_done(d0, 100, n);
    @(negedge clk);
    #1;
    check_end(1, "error_clear");
  endtask

  task automatic test_protect;
    int d0, n;
    stall_cfg = 3;
    push_seq(2);
    d0 = done_cnt;
    issue(2);
    load_word(2, 0, 32'hDEAD_0000, 1'b0);
    load_word(3, 0, 32'hBEEF_0000, 1'b1);
    load_word(3, 5, 32'h0BAD_0BAD, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL protect_busy: got %b, required 1", busy);
    end
    wait_done(d0, 200, n);
    stall_cfg = 0;
    push_seq(3);
    d0 = done_cnt;
    issue(3);
    wait_done(d0, 100, n);
    @(negedge clk);
    #1;
    check_end(3, "protect_other");
    push_seq(2);
    d0 = done_cnt;
    issue(2);
    wait_done(d0, 100, n);
    @(negedge clk);
    #1;
    check_end(2, "protect_locked");
  endtask

  task automatic test_reset_mid;
    int d0, n;
    stall_cfg = 3;
    push_seq(1);
    issue(1);
    repeat (5) @(negedge clk);
    checks++;
    if (avm_write !== 1'b1 || avm_address == 3'd0) begin
      errors++;
      $display("FAIL midrst_in_wrdata: got w=%b a=%0d, required write of data word", avm_write,
               avm_address);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, busy, done, error, cur_valid, cur_profile, avm_write, avm_read, avm_address,
         avm_writedata} !== {5'b10000, PW'(0), 37'h0}) begin
      errors++;
      $display("FAIL midrst_outputs: got rdy=%b busy=%b vld=%b w=%b a=%0d d=%h, required reset values",
               req_ready, busy, cur_valid, avm_write, avm_address, avm_writedata);
    end
    @(negedge clk);
    exp_q.delete();
    for (int p = 0; p < NP; p++) for (int w = 0; w < 5; w++) model[p][w] = 32'h0;
    stall_cfg = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready: got %b, required 1", req_ready);
    end
    push_seq(1);
    d0 = done_cnt;
    issue(1);
    wait_done(d0, 100, n);
    @(negedge clk);
    #1;
    check_end(1, "midrst_table_zero");
  endtask

  initial begin
    for (int p = 0; p < NP; p++) for (int w = 0; w < 5; w++) model[p][w] = 32'h0;
    test_reset();
    test_basic();
    test_repeat();
    test_stall();
    test_timeout();
    test_protect();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
